pipelined_carry_look_ahead_add: RTL and testbench

//  Parametrised, pipelined carry-look-ahead add/subtract unit for FixedPointArithmetic.

---
 rtl/fxp_add_pkg.sv | 35 +++
 rtl/carry_look_ahead_group.sv | 58 +++++
 rtl/pipelined_carry_look_ahead_add.sv | 169 ++++++++++++++++
 tb/tb_pipelined_carry_look_ahead_add.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fxp_add_pkg.sv
// ============================================================================
// Module      : fxp_add_pkg
// Description : Shared types, default widths and helpers for the fixed-point
//               add/subtract family.
//               - fxp_cla_pg_t : group propagate / generate pair
//               - num_groups() : number of look-ahead groups, clog2-free
//               - c_fxp_add_*  : default widths used by the Add variants
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fxp_add_pkg;

  localparam int c_fxp_add_n_default  = 32;
  localparam int c_fxp_add_gw_default = 8;

  // Group-level propagate (p) and generate (g) of a look-ahead block.
  typedef struct packed {
    logic p;
    logic g;
  } fxp_cla_pg_t;

  // Number of GW-bit groups in an N-bit word. A non-positive GW returns 1
  // so that elaboration reaches the configuration check instead of
  // dividing by zero.
  function automatic int num_groups(input int n, input int gw);
    if (gw > 0) begin
      return n / gw;
    end
    return 1;
  endfunction

endpackage : fxp_add_pkg

`default_nettype wire

// File: rtl/carry_look_ahead_group.sv
// ============================================================================
// Module      : carry_look_ahead_group
// Description : Combinational GW-bit carry-look-ahead adder group.
// Ports       : a  [GW] in  - operand A slice
//               b  [GW] in  - operand B slice (already inverted for subtract)
//               ci      in  - carry into bit 0 of the group
//               s  [GW] out - sum slice
//               co      out - carry out of the group (look-ahead form)
//               pg      out - group propagate / generate
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module carry_look_ahead_group
  import fxp_add_pkg::*;
#(
  parameter int GW = c_fxp_add_gw_default
) (
  input  logic [GW-1:0] a,
  input  logic [GW-1:0] b,
  input  logic          ci,
  output logic [GW-1:0] s,
  output logic          co,
  output fxp_cla_pg_t   pg
);

  logic [GW-1:0] w_p;
  logic [GW-1:0] w_g;
  logic [GW-1:0] w_c;    // carry into each bit of the group
  logic          w_gp;
  logic          w_gg;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // The carry recurrence is written as a loop; synthesis flattens each
  // w_c[i] into a two-level sum of products over g/p of the lower bits.
  always_comb begin
    w_c    = '0;
    w_c[0] = ci;
    w_gp   = 1'b1;
    w_gg   = 1'b0;
    for (int i = 1; i < GW; i++) begin
      w_c[i] = w_g[i-1] | (w_p[i-1] & w_c[i-1]);
    end
    for (int i = 0; i < GW; i++) begin
      w_gg = w_g[i] | (w_p[i] & w_gg);
      w_gp = w_gp & w_p[i];
    end
  end

  assign s  = w_p ^ w_c;
  assign co = w_gg | (w_gp & ci);
  assign pg = '{p: w_gp, g: w_gg};

endmodule : carry_look_ahead_group

`default_nettype wire

// File: rtl/pipelined_carry_look_ahead_add.sv
// ============================================================================
// Module      : pipelined_carry_look_ahead_add
// Description : Pipelined N-bit carry-look-ahead add/subtract with a
//               valid/ready stream interface. One GW-bit group is resolved
//               per stage (NG = N/GW stages, latency NG, one op per cycle).
//               Pending operand bits ride in shrinking skew registers and
//               finished sum bits accumulate in growing de-skew registers.
// Ports       : clk            in       - clock, rising edge
//               rst_n          in       - synchronous active-low reset
//               in_valid       in       - operand beat valid
//               in_ready       out      - beat accepted this cycle
//               a, b       [N] in       - operands
//               ci             in       - carry in (ignored when sub=1)
//               sub            in       - 1: a - b, 0: a + b + ci
//               out_valid      out      - result valid
//               out_ready      in       - consumer accepts result
//               c          [N] out      - result
//               co             out      - carry out (sub: 1 = no borrow)
//               ovf            out      - signed overflow (option only)
// Options     : FXP_ADD_OVERFLOW_EN - adds the ovf output
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_carry_look_ahead_add
  import fxp_add_pkg::*;
#(
  parameter int N  = c_fxp_add_n_default,
  parameter int GW = c_fxp_add_gw_default
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         co
`ifdef FXP_ADD_OVERFLOW_EN
  ,
  output logic         ovf
`endif
);

  localparam int NG = num_groups(N, GW);

  if (GW < 1 || GW > N) begin : g_cfg_gw
    $error("pipelined_carry_look_ahead_add: GW=%0d must be in 1..N=%0d", GW, N);
  end else if (N % GW != 0) begin : g_cfg_div
    $error("pipelined_carry_look_ahead_add: N=%0d not a multiple of GW=%0d", N, GW);
  end

  logic         w_adv;        // whole pipeline shifts this cycle
  logic [N-1:0] w_b_entry;
  logic         w_cin_entry;

  // A single global enable: the pipe never collapses bubbles, so every slot
  // keeps its position and latency stays exactly NG while advancing.
  assign w_adv       = ~out_valid | out_ready;
  assign in_ready    = w_adv;
  assign w_b_entry   = sub ? ~b : b;
  assign w_cin_entry = sub | ci;

  for (genvar k = 0; k < NG; k++) begin : g_stage
    localparam int LO = k * GW;   // lowest bit resolved by this stage
    localparam int RW = N - LO;   // operand bits still pending at its input

    logic [RW-1:0]      w_a;
    logic [RW-1:0]      w_b;
    logic               w_ci;
    logic               w_vi;
    logic [GW-1:0]      w_s;
    logic               w_co;
    fxp_cla_pg_t        w_pg;
    logic               w_unused_pg;
    logic [LO+GW-1:0]   w_s_next;

    logic               r_vld;
    logic               r_cy;
    logic [LO+GW-1:0]   r_s;

    if (k == 0) begin : g_src_port
      assign w_a      = a;
      assign w_b      = w_b_entry;
      assign w_ci     = w_cin_entry;
      assign w_vi     = in_valid;
      assign w_s_next = w_s;
    end else begin : g_src_prev
      assign w_a      = g_stage[k-1].g_skew.r_a;
      assign w_b      = g_stage[k-1].g_skew.r_b;
      assign w_ci     = g_stage[k-1].r_cy;
      assign w_vi     = g_stage[k-1].r_vld;
      assign w_s_next = {w_s, g_stage[k-1].r_s};
    end

    carry_look_ahead_group #(
      .GW (GW)
    ) u_cla (
      .a  (w_a[GW-1:0]),
      .b  (w_b[GW-1:0]),
      .ci (w_ci),
      .s  (w_s),
      .co (w_co),
      .pg (w_pg)
    );

    // Group P/G exist for multi-level look-ahead; with one group per stage
    // the registered carry already comes from co.
    assign w_unused_pg = w_pg.p ^ w_pg.g;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
        r_cy  <= 1'b0;
        r_s   <= '0;
      end else if (w_adv) begin
        r_vld <= w_vi;
        r_cy  <= w_co;
        r_s   <= w_s_next;
      end
    end

    // Skew registers carry only the operand bits later stages still need.
    if (k < NG - 1) begin : g_skew
      logic [RW-GW-1:0] r_a;
      logic [RW-GW-1:0] r_b;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a[RW-1:GW];
          r_b <= w_b[RW-1:GW];
        end
      end
    end

`ifdef FXP_ADD_OVERFLOW_EN
    // The top group still holds the operand sign bits, so overflow is
    // resolved here without carrying signs through earlier stages.
    if (k == NG - 1) begin : g_ovf
      logic r_ovf;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= (w_a[RW-1] == w_b[RW-1]) & (w_s[GW-1] != w_a[RW-1]);
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[NG-1].r_vld;
  assign c         = g_stage[NG-1].r_s;
  assign co        = g_stage[NG-1].r_cy;
`ifdef FXP_ADD_OVERFLOW_EN
  assign ovf       = g_stage[NG-1].g_ovf.r_ovf;
`endif

endmodule : pipelined_carry_look_ahead_add

`default_nettype wire

// File: tb/tb_pipelined_carry_look_ahead_add.sv
// ============================================================================
// Module      : tb_pipelined_carry_look_ahead_add
// Description : Scoreboard bench for pipelined_carry_look_ahead_add
//               (N=32, GW=8). Stimulus pushes expected results into a queue;
//               a monitor pops and compares on every out_valid & out_ready.
//               Checks ovf when FXP_ADD_OVERFLOW_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pipelined_carry_look_ahead_add;

  localparam int N  = 32;
  localparam int GW = 8;
  localparam int NG = N / GW;
  localparam int ND = 10;

  typedef struct {
    logic [N-1:0] c;
    logic         co;
    logic         ovf;
    int           acc;
    bit           chk_lat;
  } exp_t;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ci;
    logic         sub;
    logic [N-1:0] c;
    logic         co;
    logic         ovf;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ci;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] c;
  logic         co;
`ifdef FXP_ADD_OVERFLOW_EN
  logic         ovf;
`endif

  exp_t sb_q[$];
  exp_t m_e;
  vec_t vecs [ND];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_out  = 0;

  pipelined_carry_look_ahead_add #(
    .N  (N),
    .GW (GW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .co        (co)
`ifdef FXP_ADD_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] fa, input logic [N-1:0] fb,
                                 input logic fci, input logic fsub);
    exp_t         e;
    logic [N-1:0] bb;
    logic [N:0]   sum;
    bb        = fsub ? ~fb : fb;
    sum       = {1'b0, fa} + {1'b0, bb} + {{N{1'b0}}, (fsub | fci)};
    e.c       = sum[N-1:0];
    e.co      = sum[N];
    e.ovf     = (fa[N-1] == bb[N-1]) && (sum[N-1] != fa[N-1]);
    e.acc     = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  // Present one beat (called just after a rising edge); returns just after
  // the edge that accepted it, so back-to-back calls give back-to-back beats.
  task automatic drive(input logic [N-1:0] da, input logic [N-1:0] db, input logic dci,
                       input logic dsub, input exp_t e, input bit lat);
    bit done;
    done     = 1'b0;
    a        = da;
    b        = db;
    ci       = dci;
    sub      = dsub;
    in_valid = 1'b1;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e.acc     = cyc;
        e.chk_lat = lat;
        sb_q.push_back(e);
        done      = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=in_ready_low required=accepted");
    end
  endtask

  task automatic wait_drain(input int limit);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < limit) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: compare every consumed result against the head of the queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=0x%0h required=none", c);
      end else begin
        m_e = sb_q.pop_front();
        check("result_c", c, m_e.c);
        check("result_co", co, m_e.co);
`ifdef FXP_ADD_OVERFLOW_EN
        check("result_ovf", ovf, m_e.ovf);
`endif
        if (m_e.chk_lat) check("latency", cyc - m_e.acc, NG);
      end
    end
  end

  initial begin
    exp_t         e;
    logic [N-1:0] va;
    logic [N-1:0] vb;
    int           start;
    int           n0;

    //            a             b             ci    sub   c             co    ovf
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0};
    vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[6] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[7] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
    vecs[8] = '{32'h0000_0003, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    ci        = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_c", c, 0);
    check("reset_co", co, 0);
`ifdef FXP_ADD_OVERFLOW_EN
    check("reset_ovf", ovf, 0);
`endif
    @(posedge clk);
    #1;

    // Directed vectors, back-to-back, exact latency checked
    for (int i = 0; i < ND; i++) begin
      e.c   = vecs[i].c;
      e.co  = vecs[i].co;
      e.ovf = vecs[i].ovf;
      drive(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, e, 1'b1);
    end
    in_valid = 1'b0;
    wait_drain(50);

    // Back-to-back stream: one accept per cycle, results in order
    start = cyc;
    for (int i = 0; i < 40; i++) begin
      va = 32'h9E37_79B9 * (i + 1);
      vb = {va[15:0], va[31:16]} ^ 32'h5A5A_0F0F;
      if (i % 8 == 3) va = 32'hFFFF_FFFF;
      drive(va, vb, i[1], i[0], model(va, vb, i[1], i[0]), 1'b1);
    end
    check("stream_accept_cycles", cyc - start, 40);
    in_valid = 1'b0;
    wait_drain(50);

    // Output stall with the pipeline full
    out_ready = 1'b0;
    for (int i = 0; i < NG; i++) begin
      va = 32'h0F0F_0000 + i;
      vb = 32'h00F0_FFFF - i;
      drive(va, vb, 1'b1, 1'b0, model(va, vb, 1'b1, 1'b0), 1'b0);
    end
    in_valid = 1'b0;
    check("stall_queue_depth", sb_q.size(), NG);
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      if (sb_q.size() > 0) begin
        check("stall_c", c, sb_q[0].c);
        check("stall_co", co, sb_q[0].co);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_drain(50);

    // Reset with three beats in flight: none of them may emerge
    for (int i = 0; i < 3; i++) begin
      va = 32'hA000_0000 + i;
      drive(va, 32'h1, 1'b0, 1'b0, model(va, 32'h1, 1'b0, 1'b0), 1'b0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    sb_q.delete();
    n0       = n_out;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_c", c, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_in_ready", in_ready, 1);
    repeat (10) @(posedge clk);
    #1;
    check("rst_mid_no_result", n_out - n0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipelined_carry_look_ahead_add

`default_nettype wire
